// File: rtl/tcp_conn_sched.sv
// Round-robin handshake scheduler: one SYN-ACK/ACK engine shared by N_CLIENTS requesters,
// with timeout, bounded retransmission and per-client ESTABLISHED tracking.
module tcp_conn_sched #(
    parameter int N_CLIENTS = 4,
    parameter int SEQ_W     = 8,
    parameter int ISN_BASE  = 200,
    parameter int ISN_STEP  = 64,
    parameter int TIMEOUT   = 16,
    parameter int MAX_RETRY = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_CLIENTS-1:0]         syn_req,
    input  logic [N_CLIENTS*SEQ_W-1:0]   syn_seq_in,
    input  logic [N_CLIENTS-1:0]         close_req,
    input  logic                         ack_valid,
    input  logic [$clog2(N_CLIENTS)-1:0] ack_id,
    input  logic [SEQ_W-1:0]             ack_seq,
    input  logic [SEQ_W-1:0]             ack_ack,
    output logic [N_CLIENTS-1:0]         grant,
    output logic                         send_syn_ack,
    output logic [$clog2(N_CLIENTS)-1:0] tx_id,
    output logic [SEQ_W-1:0]             tx_seq,
    output logic [SEQ_W-1:0]             tx_ack,
    output logic [N_CLIENTS-1:0]         established,
    output logic                         conn_done,
    output logic                         conn_fail,
    output logic                         busy
);

    localparam int ID_W    = $clog2(N_CLIENTS);
    localparam int TIMER_W = $clog2(TIMEOUT + 1);
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);
    localparam logic [N_CLIENTS-1:0] ONE_HOT0 = N_CLIENTS'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        WAIT_ACK = 2'd2
    } state_t;

    state_t               state, state_n;
    logic [ID_W-1:0]      cur_id;
    logic [SEQ_W-1:0]     cur_seq;
    logic [ID_W-1:0]      rr_ptr;
    logic [SEQ_W-1:0]     isn;
    logic [RETRY_W-1:0]   retry;
    logic [TIMER_W-1:0]   timer;

    logic [N_CLIENTS-1:0] eligible;
    logic                 pick_valid;
    logic [ID_W-1:0]      pick_id;
    logic                 ack_match;
    logic [ID_W-1:0]      next_rr;
    logic [N_CLIENTS-1:0] cur_onehot;
    logic                 ev_abort, ev_done, ev_retry, ev_fail;

    assign eligible   = syn_req & ~established & ~close_req;
    assign cur_onehot = ONE_HOT0 << cur_id;
    assign next_rr    = (cur_id == ID_W'(N_CLIENTS - 1)) ? '0 : cur_id + ID_W'(1);

    // ack_valid is a one-cycle strobe with no back-pressure: an ACK is consumed
    // (matched or dropped) in the cycle it is presented, only while in WAIT_ACK.
    assign ack_match = ack_valid && (ack_id == cur_id) &&
                       (ack_ack == isn + SEQ_W'(1)) &&
                       (ack_seq == cur_seq + SEQ_W'(1));

    // First eligible client searching upward from rr_ptr, wrapping at N_CLIENTS.
    always_comb begin : pick_blk
        int idx;
        pick_valid = 1'b0;
        pick_id    = '0;
        idx        = 0;
        for (int k = 0; k < N_CLIENTS; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_CLIENTS) idx = idx - N_CLIENTS;
            if (!pick_valid && eligible[idx]) begin
                pick_valid = 1'b1;
                pick_id    = ID_W'(idx);
            end
        end
    end

    always_comb begin
        state_n  = state;
        ev_abort = 1'b0;
        ev_done  = 1'b0;
        ev_retry = 1'b0;
        ev_fail  = 1'b0;
        case (state)
            IDLE: begin
                if (pick_valid) state_n = SEND;
            end
            SEND: begin
                state_n = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (close_req[cur_id]) begin
                    ev_abort = 1'b1;
                    state_n  = IDLE;
                end else if (ack_match) begin
                    ev_done = 1'b1;
                    state_n = IDLE;
                end else if (timer == TIMER_W'(TIMEOUT - 1)) begin
                    if (retry < RETRY_W'(MAX_RETRY)) begin
                        ev_retry = 1'b1;
                        state_n  = SEND;
                    end else begin
                        ev_fail = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            grant        <= '0;
            send_syn_ack <= 1'b0;
            tx_id        <= '0;
            tx_seq       <= '0;
            tx_ack       <= '0;
            established  <= '0;
            conn_done    <= 1'b0;
            conn_fail    <= 1'b0;
            busy         <= 1'b0;
            rr_ptr       <= '0;
            isn          <= SEQ_W'(ISN_BASE);
            retry        <= '0;
            timer        <= '0;
            cur_id       <= '0;
            cur_seq      <= '0;
        end else begin
            state        <= state_n;
            busy         <= (state_n != IDLE);
            send_syn_ack <= (state == SEND);
            conn_done    <= ev_done;
            conn_fail    <= ev_fail;
            established  <= (established & ~close_req) | (ev_done ? cur_onehot : '0);

            if (state == IDLE && pick_valid) begin
                cur_id  <= pick_id;
                cur_seq <= syn_seq_in[int'(pick_id)*SEQ_W +: SEQ_W];
                grant   <= ONE_HOT0 << pick_id;
            end

            // Retransmissions reuse cur_seq and isn, so tx fields repeat exactly.
            if (state == SEND) begin
                tx_id  <= cur_id;
                tx_seq <= isn;
                tx_ack <= cur_seq + SEQ_W'(1);
                timer  <= '0;
            end else if (state == WAIT_ACK) begin
                timer <= timer + TIMER_W'(1);
            end

            if (ev_abort || ev_done || ev_fail) begin
                grant  <= '0;
                rr_ptr <= next_rr;
            end
            if (ev_done) isn <= isn + SEQ_W'(ISN_STEP);
            if (ev_retry) retry <= retry + RETRY_W'(1);
            if (ev_done || ev_fail) retry <= '0;
        end
    end

endmodule

// File: tb/tb_tcp_conn_sched.sv
// Directed bench for tcp_conn_sched: single handshake, round-robin order, retry/fail,
// bad ACKs, ACK-vs-timeout race, sequence wrap, teardown and async reset.
module tb_tcp_conn_sched;

    logic        clk;
    logic        reset;
    logic [3:0]  syn_req;
    logic [31:0] syn_seq_in;
    logic [3:0]  close_req;
    logic        ack_valid;
    logic [1:0]  ack_id;
    logic [7:0]  ack_seq;
    logic [7:0]  ack_ack;
    logic [3:0]  grant;
    logic        send_syn_ack;
    logic [1:0]  tx_id;
    logic [7:0]  tx_seq;
    logic [7:0]  tx_ack;
    logic [3:0]  established;
    logic        conn_done;
    logic        conn_fail;
    logic        busy;

    int errors = 0;
    int checks = 0;

    tcp_conn_sched dut (
        .clk          (clk),
        .reset        (reset),
        .syn_req      (syn_req),
        .syn_seq_in   (syn_seq_in),
        .close_req    (close_req),
        .ack_valid    (ack_valid),
        .ack_id       (ack_id),
        .ack_seq      (ack_seq),
        .ack_ack      (ack_ack),
        .grant        (grant),
        .send_syn_ack (send_syn_ack),
        .tx_id        (tx_id),
        .tx_seq       (tx_seq),
        .tx_ack       (tx_ack),
        .established  (established),
        .conn_done    (conn_done),
        .conn_fail    (conn_fail),
        .busy         (busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_seq(input int id, input logic [7:0] v);
        syn_seq_in[id*8 +: 8] = v;
    endtask

    task automatic drive_ack(input logic [1:0] id, input logic [7:0] s, input logic [7:0] a);
        ack_valid = 1'b1;
        ack_id    = id;
        ack_seq   = s;
        ack_ack   = a;
    endtask

    task automatic clear_ack();
        ack_valid = 1'b0;
        ack_id    = '0;
        ack_seq   = '0;
        ack_ack   = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic check_tx(input string tag, input logic [1:0] id, input logic [7:0] s,
                            input logic [7:0] a);
        check({tag, "_send"}, 32'(send_syn_ack), 32'd1);
        check({tag, "_tx_id"}, 32'(tx_id), 32'(id));
        check({tag, "_tx_seq"}, 32'(tx_seq), 32'(s));
        check({tag, "_tx_ack"}, 32'(tx_ack), 32'(a));
    endtask

    initial begin
        reset = 1'b1;
        syn_req = '0;
        syn_seq_in = '0;
        close_req = '0;
        clear_ack();
        tick();

        // reset state
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_send", 32'(send_syn_ack), 32'd0);
        check("rst_tx_seq", 32'(tx_seq), 32'd0);
        check("rst_est", 32'(established), 32'd0);
        check("rst_done_fail", 32'({conn_done, conn_fail}), 32'd0);
        reset = 1'b0;
        tick();

        // single client 1, seq 10
        syn_req = 4'b0010;
        set_seq(1, 8'd10);
        tick();
        check("single_grant", 32'(grant), 32'b0010);
        check("single_busy", 32'(busy), 32'd1);
        check("single_nosend", 32'(send_syn_ack), 32'd0);
        tick();
        check_tx("single", 2'd1, 8'd200, 8'd11);
        drive_ack(2'd1, 8'd11, 8'd201);
        tick();
        clear_ack();
        syn_req = '0;
        check("single_done", 32'(conn_done), 32'd1);
        check("single_est", 32'(established), 32'b0010);
        check("single_busy0", 32'(busy), 32'd0);
        check("single_grant0", 32'(grant), 32'd0);
        tick();
        check("single_done_pulse", 32'(conn_done), 32'd0);

        // round robin over 0,1,3 from a fresh reset
        do_reset();
        syn_req = 4'b1011;
        set_seq(0, 8'd20);
        set_seq(1, 8'd30);
        set_seq(3, 8'd40);
        tick();
        check("rr0_grant", 32'(grant), 32'b0001);
        tick();
        check_tx("rr0", 2'd0, 8'd200, 8'd21);
        drive_ack(2'd0, 8'd21, 8'd201);
        tick();
        clear_ack();
        check("rr0_done", 32'(conn_done), 32'd1);
        check("rr0_est", 32'(established), 32'b0001);
        tick();
        check("rr1_grant", 32'(grant), 32'b0010);
        tick();
        check_tx("rr1", 2'd1, 8'd8, 8'd31);
        drive_ack(2'd1, 8'd31, 8'd9);
        tick();
        clear_ack();
        check("rr1_est", 32'(established), 32'b0011);
        tick();
        check("rr3_grant", 32'(grant), 32'b1000);
        tick();
        check_tx("rr3", 2'd3, 8'd72, 8'd41);
        drive_ack(2'd3, 8'd41, 8'd73);
        tick();
        clear_ack();
        syn_req = '0;
        check("rr3_est", 32'(established), 32'b1011);
        tick();
        check("rr_idle", 32'(busy), 32'd0);

        // close an established client while it re-requests; eligible the cycle after
        syn_req = 4'b0010;
        close_req = 4'b0010;
        tick();
        close_req = '0;
        check("close_est", 32'(established), 32'b1001);
        check("close_nograntyet", 32'(grant), 32'd0);
        tick();
        check("reelig_grant", 32'(grant), 32'b0010);
        tick();
        check_tx("reelig", 2'd1, 8'd136, 8'd31);
        tick();
        // teardown of the current client during WAIT_ACK
        syn_req = '0;
        close_req = 4'b0010;
        tick();
        close_req = '0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_grant", 32'(grant), 32'd0);
        check("abort_pulses", 32'({conn_done, conn_fail}), 32'd0);
        check("abort_est", 32'(established), 32'b1001);
        tick();
        check("abort_nosend", 32'(send_syn_ack), 32'd0);

        // retry/fail on client 2 with seq wrap, plus bad ACKs during the first wait
        do_reset();
        syn_req = 4'b0100;
        set_seq(2, 8'd255);
        tick();
        check("to_grant", 32'(grant), 32'b0100);
        tick();
        check_tx("to_p0", 2'd2, 8'd200, 8'd0);
        syn_req = '0;
        for (int p = 1; p <= 3; p++) begin
            for (int i = 1; i <= 16; i++) begin
                tick();
                clear_ack();
                if (p == 1 && i == 3) drive_ack(2'd2, 8'd0, 8'd202);
                if (p == 1 && i == 5) drive_ack(2'd1, 8'd0, 8'd201);
            end
            check("to_gap_nosend", 32'(send_syn_ack), 32'd0);
            check("to_gap_busy", 32'(busy), 32'd1);
            tick();
            check_tx("to_retx", 2'd2, 8'd200, 8'd0);
        end
        check("to_est_unchanged", 32'(established), 32'd0);
        repeat (15) tick();
        check("to_prefail", 32'(conn_fail), 32'd0);
        tick();
        check("to_fail", 32'(conn_fail), 32'd1);
        check("to_fail_busy", 32'(busy), 32'd0);
        check("to_fail_grant", 32'(grant), 32'd0);
        check("to_fail_est", 32'(established), 32'd0);
        tick();
        check("to_fail_pulse", 32'(conn_fail), 32'd0);

        // isn unchanged after failure; correct ACK in the timeout cycle wins
        syn_req = 4'b0010;
        set_seq(1, 8'd5);
        tick();
        tick();
        check_tx("race", 2'd1, 8'd200, 8'd6);
        syn_req = '0;
        repeat (15) tick();
        drive_ack(2'd1, 8'd6, 8'd201);
        tick();
        clear_ack();
        check("race_done", 32'(conn_done), 32'd1);
        check("race_est", 32'(established), 32'b0010);
        check("race_busy", 32'(busy), 32'd0);
        tick();
        check("race_noretx", 32'(send_syn_ack), 32'd0);

        // async reset during WAIT_ACK
        syn_req = 4'b0001;
        set_seq(0, 8'd1);
        tick();
        tick();
        check_tx("ar_pre", 2'd0, 8'd8, 8'd2);
        tick();
        #2;
        reset = 1'b1;
        #1;
        check("ar_grant", 32'(grant), 32'd0);
        check("ar_busy", 32'(busy), 32'd0);
        check("ar_tx", 32'({tx_id, tx_seq, tx_ack}), 32'd0);
        check("ar_est", 32'(established), 32'd0);
        check("ar_pulses", 32'({send_syn_ack, conn_done, conn_fail}), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        check("ar_regrant", 32'(grant), 32'b0001);
        tick();
        check_tx("ar_post", 2'd0, 8'd200, 8'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
